// File: rtl/usb2_ep_ring_if.sv
// Buffer, handshake and PID bundle between the protocol layer and the
// ring-buffered endpoint.
interface usb2_ep_ring_if #(
  parameter int BUF_AW = 10,
  parameter int PW     = 2
);
  logic [BUF_AW-1:0] buf_in_addr;
  logic [7:0]        buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [BUF_AW:0]   buf_in_commit_len;
  logic              buf_in_commit_ack;
  logic [BUF_AW-1:0] buf_out_addr;
  logic [7:0]        buf_out_q;
  logic [BUF_AW:0]   buf_out_len;
  logic              buf_out_hasdata;
  logic              buf_out_arm;
  logic              buf_out_arm_ack;
  logic              buf_out_clear;
  logic [1:0]        mode;
  logic              setconfig;
  logic              sof_arrived;
  logic              data_toggle_act;
  logic [1:0]        data_toggle;
  logic [PW:0]       fill_count;
  logic              commit_drop;

  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren,
    output buf_in_commit, buf_in_commit_len,
    output buf_out_addr, buf_out_arm, buf_out_clear,
    output mode, setconfig, sof_arrived, data_toggle_act,
    input  buf_in_ready, buf_in_commit_ack,
    input  buf_out_q, buf_out_len, buf_out_hasdata,
    input  buf_out_arm_ack, data_toggle,
    input  fill_count, commit_drop
  );

  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren,
    input  buf_in_commit, buf_in_commit_len,
    input  buf_out_addr, buf_out_arm, buf_out_clear,
    input  mode, setconfig, sof_arrived, data_toggle_act,
    output buf_in_ready, buf_in_commit_ack,
    output buf_out_q, buf_out_len, buf_out_hasdata,
    output buf_out_arm_ack, data_toggle,
    output fill_count, commit_drop
  );
endinterface

// File: rtl/usb2_ep_ring.sv
// N-deep ring of USB 2.0 endpoint packet buffers with occupancy,
// drop detection and high-bandwidth isoch PID sequencing.
module usb2_ep_ring #(
  parameter int NUM_BUF = 4,
  parameter int BUF_AW  = 10,
  parameter int PW      = 2
) (
  input logic           phy_clk,
  input logic           reset_n,
  usb2_ep_ring_if.slave bus
);

  localparam int DEPTH  = NUM_BUF << BUF_AW;
  localparam int MAXLEN = 1 << BUF_AW;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [BUF_AW:0] len_q [NUM_BUF];
  logic [7:0]      mem [DEPTH];
  logic [7:0]      q;
  logic            commit_d;
  logic            arm_d;
  logic            clear_d;
  logic            setcfg_d;
  logic            sof_d;
  logic            commit_ack;
  logic            arm_ack;
  logic            drop;
  logic [1:0]      tog;

  logic            commit_ev;
  logic            arm_ev;
  logic            clear_ev;
  logic            setcfg_ev;
  logic            sof_ev;
  logic            full;
  logic            ready;
  logic            commit_ok;
  logic            arm_ok;
  logic            iso;
  logic [BUF_AW:0] len_clamp;

  assign commit_ev = bus.buf_in_commit & ~commit_d;
  assign arm_ev    = bus.buf_out_arm & ~arm_d;
  assign clear_ev  = bus.buf_out_clear & ~clear_d;
  assign setcfg_ev = bus.setconfig ^ setcfg_d;
  assign sof_ev    = bus.sof_arrived ^ sof_d;
  assign full      = count == (PW+1)'(NUM_BUF);
  assign ready     = ~full;
  assign iso       = bus.mode == 2'd1;

  // Acceptance uses the count held before this cycle.
  assign commit_ok = commit_ev & ~full & ~clear_ev;
  assign arm_ok    = arm_ev & (count != '0) & ~clear_ev;

  assign len_clamp =
    (bus.buf_in_commit_len > (BUF_AW+1)'(MAXLEN)) ?
    (BUF_AW+1)'(MAXLEN) : bus.buf_in_commit_len;

  assign bus.buf_in_ready      = ready;
  assign bus.buf_in_commit_ack = commit_ack;
  assign bus.buf_out_arm_ack   = arm_ack;
  assign bus.buf_out_q         = q;
  assign bus.buf_out_hasdata   = count != '0;
  assign bus.buf_out_len       =
    (count != '0) ? len_q[rd_ptr] : '0;
  assign bus.fill_count        = count;
  assign bus.commit_drop       = drop;
  assign bus.data_toggle       = tog;

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      commit_d   <= 1'b0;
      arm_d      <= 1'b0;
      clear_d    <= 1'b0;
      commit_ack <= 1'b0;
      arm_ack    <= 1'b0;
      drop       <= 1'b0;
      for (int i = 0; i < NUM_BUF; i++)
        len_q[i] <= '0;
    end else begin
      commit_d   <= bus.buf_in_commit;
      arm_d      <= bus.buf_out_arm;
      clear_d    <= bus.buf_out_clear;
      commit_ack <= commit_ok;
      arm_ack    <= arm_ev & ~clear_ev;
      if (clear_ev) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        drop   <= 1'b0;
      end else begin
        if (commit_ok) begin
          len_q[wr_ptr] <= len_clamp;
          wr_ptr        <= wr_ptr + 1'b1;
        end
        if (arm_ok)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{PW{1'b0}}, commit_ok}
                       - {{PW{1'b0}}, arm_ok};
        if (commit_ev && full)
          drop <= 1'b1;
      end
    end
  end

  // Highest-priority event is tested first.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      tog      <= 2'd0;
      setcfg_d <= 1'b0;
      sof_d    <= 1'b0;
    end else begin
      setcfg_d <= bus.setconfig;
      sof_d    <= bus.sof_arrived;
      if (bus.data_toggle_act && !iso)
        tog <= (tog == 2'd0) ? 2'd1 : 2'd0;
      else if (bus.data_toggle_act && iso)
        tog <= (tog == 2'd0) ? 2'd0 : tog - 2'd1;
      else if (sof_ev && iso)
        tog <= (count >= (PW+1)'(3)) ? 2'd2 :
               (count == (PW+1)'(2)) ? 2'd1 : 2'd0;
      else if (setcfg_ev)
        tog <= 2'd0;
    end
  end

  always_ff @(posedge phy_clk) begin
    if (bus.buf_in_wren && ready)
      mem[{wr_ptr, bus.buf_in_addr}] <= bus.buf_in_data;
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n)
      q <= 8'd0;
    else
      q <= mem[{rd_ptr, bus.buf_out_addr}];
  end

endmodule

// File: tb/tb_usb2_ep_ring.sv
// Scoreboard bench for usb2_ep_ring: packet bytes and lengths are queued
// on write/commit and popped on readback.
module tb_usb2_ep_ring;

  localparam int NUM_BUF = 4;
  localparam int BUF_AW  = 10;
  localparam int PW      = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [7:0]      exp_q [$];
  logic [BUF_AW:0] exp_len [$];

  usb2_ep_ring_if #(.BUF_AW(BUF_AW), .PW(PW)) bus ();

  usb2_ep_ring #(
    .NUM_BUF(NUM_BUF),
    .BUF_AW (BUF_AW),
    .PW     (PW)
  ) dut (
    .phy_clk(clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_commit(input int len, input logic ack);
    bus.buf_in_commit_len = (BUF_AW+1)'(len);
    bus.buf_in_commit     = 1'b1;
    tick();
    check("commit_ack", bus.buf_in_commit_ack, ack);
    bus.buf_in_commit = 1'b0;
    tick();
  endtask

  task automatic do_arm();
    bus.buf_out_arm = 1'b1;
    tick();
    check("arm_ack", bus.buf_out_arm_ack, 1);
    bus.buf_out_arm = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    bus.buf_out_clear = 1'b1;
    tick();
    bus.buf_out_clear = 1'b0;
    tick();
  endtask

  task automatic write_pkt(input int seed);
    for (int a = 0; a < 4; a++) begin
      bus.buf_in_addr = BUF_AW'(a);
      bus.buf_in_data = 8'((seed * 37 + a * 11 + 5) & 255);
      bus.buf_in_wren = 1'b1;
      exp_q.push_back(bus.buf_in_data);
      tick();
    end
    bus.buf_in_wren = 1'b0;
  endtask

  task automatic read_pkt();
    logic [BUF_AW:0] el;
    logic [7:0]      eb;
    if (exp_len.size() == 0) begin
      check("len_queue_empty", 1, 0);
      return;
    end
    el = exp_len.pop_front();
    check("ring_len", bus.buf_out_len, el);
    for (int a = 0; a < 4; a++) begin
      bus.buf_out_addr = BUF_AW'(a);
      tick();
      eb = exp_q.pop_front();
      check("ring_data", bus.buf_out_q, eb);
    end
  endtask

  task automatic act_pulse(input logic [1:0] exp);
    bus.data_toggle_act = 1'b1;
    tick();
    bus.data_toggle_act = 1'b0;
    check("toggle_act", bus.data_toggle, exp);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.buf_in_addr       = '0;
    bus.buf_in_data       = '0;
    bus.buf_in_wren       = 1'b0;
    bus.buf_in_commit     = 1'b0;
    bus.buf_in_commit_len = '0;
    bus.buf_out_addr      = '0;
    bus.buf_out_arm       = 1'b0;
    bus.buf_out_clear     = 1'b0;
    bus.mode              = 2'd2;
    bus.setconfig         = 1'b0;
    bus.sof_arrived       = 1'b0;
    bus.data_toggle_act   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.buf_in_ready, 1);
    check("rst_hasdata", bus.buf_out_hasdata, 0);
    check("rst_count", bus.fill_count, 0);
    check("rst_drop", bus.commit_drop, 0);
    check("rst_toggle", bus.data_toggle, 0);
    check("rst_q", bus.buf_out_q, 0);
    check("rst_len", bus.buf_out_len, 0);
    check("rst_cack", bus.buf_in_commit_ack, 0);
    check("rst_aack", bus.buf_out_arm_ack, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 1; i <= 4; i++)
      do_commit(i * 10, 1'b1);
    check("full_count", bus.fill_count, 4);
    check("full_ready", bus.buf_in_ready, 0);
    check("full_len", bus.buf_out_len, 10);

    do_commit(99, 1'b0);
    check("drop_flag", bus.commit_drop, 1);
    check("drop_count", bus.fill_count, 4);

    do_arm();
    check("arm_len", bus.buf_out_len, 20);
    check("arm_count", bus.fill_count, 3);
    do_clear();
    check("clr_count", bus.fill_count, 0);
    check("clr_drop", bus.commit_drop, 0);
    check("clr_hasdata", bus.buf_out_hasdata, 0);

    do_commit(50, 1'b1);
    do_commit(60, 1'b1);
    bus.buf_in_commit_len = 11'd70;
    bus.buf_in_commit     = 1'b1;
    bus.buf_out_arm       = 1'b1;
    tick();
    check("both_cack", bus.buf_in_commit_ack, 1);
    check("both_aack", bus.buf_out_arm_ack, 1);
    check("both_count", bus.fill_count, 2);
    check("both_len", bus.buf_out_len, 60);
    bus.buf_in_commit = 1'b0;
    bus.buf_out_arm   = 1'b0;
    tick();
    do_arm();
    check("drain_len", bus.buf_out_len, 70);
    do_arm();
    do_arm();
    check("empty_arm_count", bus.fill_count, 0);

    for (int i = 0; i < 9; i++) begin
      write_pkt(i);
      exp_len.push_back((BUF_AW+1)'(i + 1));
      do_commit(i + 1, 1'b1);
      if (i > 0) begin
        read_pkt();
        do_arm();
      end
    end
    read_pkt();
    do_arm();
    check("ring_count", bus.fill_count, 0);
    check("ring_sb_empty", exp_q.size(), 0);

    do_clear();
    for (int i = 0; i < 3; i++)
      do_commit(i + 1, 1'b1);
    bus.mode = 2'd1;
    bus.sof_arrived = ~bus.sof_arrived;
    tick();
    check("iso_sof", bus.data_toggle, 2);
    act_pulse(2'd1);
    act_pulse(2'd0);
    act_pulse(2'd0);

    bus.mode = 2'd2;
    act_pulse(2'd1);
    act_pulse(2'd0);
    act_pulse(2'd1);
    bus.setconfig = ~bus.setconfig;
    tick();
    check("setconfig", bus.data_toggle, 0);

    do_clear();
    do_commit(2047, 1'b1);
    check("len_clamp", bus.buf_out_len, 1024);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
